// File: rtl/pp_input_pkg.sv
// pp_input_pkg: shared constants for the button input path.
// Contents:
//   - BTN_P1L..BTN_P2R : bit positions of each button in the N_BTN vectors.
//   - move_state_t     : state encoding of the per-channel move/auto-repeat FSM.
package pp_input_pkg;
  localparam int BTN_P1L = 0;
  localparam int BTN_P1R = 1;
  localparam int BTN_P2L = 2;
  localparam int BTN_P2R = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} move_state_t;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: bundle between the board pins, the conditioner and the game core.
// Signals:
//   btn_n     : raw active-low buttons {p2r, p2l, p1r, p1l}, driven by the board side
//   level     : debounced state, 1 = held
//   press     : one-cycle pulse on an accepted press
//   rel       : one-cycle pulse on an accepted release
//   move      : press pulse followed by auto-repeat pulses while held
//   any_press : OR of press
// Modports:
//   master : the conditioner
//   slave  : board pins / game core
interface button_conditioner_if #(parameter int N_BTN = 4);
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rel;
  logic [N_BTN-1:0] move;
  logic             any_press;
  modport master (input btn_n, output level, press, rel, move, any_press);
  modport slave  (output btn_n, input level, press, rel, move, any_press);
endinterface

// File: rtl/button_conditioner_channel.sv
// btn_channel: synchronizer, debounce and move pulse generator for one button.
// Build option: AUTOREPEAT_EN adds the DELAY/REPEAT auto-repeat FSM; without it move == press.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   btn_n : raw active-low button
//   level : debounced level
//   press : pulse on accepted 0->1
//   rel   : pulse on accepted 1->0
//   move  : move pulse stream
module btn_channel
  import pp_input_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
`ifdef AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic rel,
  output logic move
);
  logic             sync1, sync2, s, accept;
  logic [CNT_W-1:0] db_cnt;
  assign s      = ~sync2;
  // accept is the edge on which the new level is taken; the counter clears on the same edge
  assign accept = (s != level) && (db_cnt == CNT_W'(DB_CYCLES - 1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1  <= btn_n;
      sync2  <= sync1;
      db_cnt <= (s == level || accept) ? '0 : db_cnt + 1'b1;
      level  <= accept ? s : level;
      press  <= accept & s;
      rel    <= accept & ~s;
    end
  end
`ifdef AUTOREPEAT_EN
  // repeat counter is sized from the repeat intervals themselves so long delays always fit
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  move_state_t      state, state_nxt;
  logic [RPT_W-1:0] rpt_cnt, rpt_nxt, rpt_last;
  logic             move_nxt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      move    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_nxt;
      move    <= move_nxt;
    end
  end
  assign rpt_last = (state == DELAY) ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
  // release wins over a coinciding repeat deadline, so no move in the release cycle
  always_comb begin
    state_nxt = state;
    rpt_nxt   = '0;
    move_nxt  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = (accept & s) ? DELAY : IDLE;
        move_nxt  = accept & s;
      end
      DELAY, REPEAT: begin
        if (accept & ~s) state_nxt = IDLE;
        else if (rpt_cnt == rpt_last) begin
          state_nxt = REPEAT;
          move_nxt  = 1'b1;
        end else rpt_nxt = rpt_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign move = press;
`endif
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: turns raw bouncing active-low player buttons into clean synchronous pulses.
// Build option: AUTOREPEAT_EN enables auto-repeat on move; otherwise move == press.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : button_conditioner_if.master (btn_n in; level, press, rel, move, any_press out)
module button_conditioner #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 500000,
  parameter int CNT_W         = 20,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input logic                  clk,
  input logic                  reset,
  button_conditioner_if.master bus
);
  if (DB_CYCLES < 1 || DB_CYCLES > 2 ** CNT_W) begin : g_bad_db
    $error("DB_CYCLES must be >= 1 and fit in CNT_W bits");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_rpt
    $error("REPEAT_DELAY must be >= 1 and REPEAT_PERIOD >= 2");
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W(CNT_W)
`ifdef AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .btn_n(bus.btn_n[i]),
      .level(bus.level[i]),
      .press(bus.press[i]),
      .rel(bus.rel[i]),
      .move(bus.move[i])
    );
  end
  assign bus.any_press = |bus.press;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_button_conditioner;
  import pp_input_pkg::*;
  typedef struct {
    int         c;
    logic [3:0] lv, pr, rl, mv;
    logic       ap;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0, pass_cnt = 0, chk_cnt = 0;
  int   k, r;
  exp_t sb[$];
  exp_t mon_e;
  button_conditioner_if #(.N_BTN(4)) bus ();
  button_conditioner #(
    .N_BTN(4),
    .DB_CYCLES(4),
    .CNT_W(8),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  function automatic void expect_ev(int c, logic [3:0] lv, logic [3:0] pr, logic [3:0] rl, logic [3:0] mv);
    sb.push_back('{c: c, lv: lv, pr: pr, rl: rl, mv: mv, ap: |pr});
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      while (sb.size() > 0 && sb[0].c < cyc) begin
        mon_e = sb.pop_front();
        chk_cnt++;
        $display("FAIL missing_event: got nothing at %0d, want pr=%b rl=%b mv=%b", mon_e.c, mon_e.pr, mon_e.rl, mon_e.mv);
      end
      if (|{bus.press, bus.rel, bus.move, bus.any_press}) begin
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_event: got at %0d lv=%b pr=%b rl=%b mv=%b ap=%b, want no output", cyc, bus.level, bus.press, bus.rel, bus.move, bus.any_press);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.c == cyc && {bus.level, bus.press, bus.rel, bus.move, bus.any_press} === {mon_e.lv, mon_e.pr, mon_e.rl, mon_e.mv, mon_e.ap})
            pass_cnt++;
          else
            $display("FAIL event: got c=%0d lv=%b pr=%b rl=%b mv=%b ap=%b, want c=%0d lv=%b pr=%b rl=%b mv=%b ap=%b", cyc, bus.level, bus.press, bus.rel, bus.move, bus.any_press, mon_e.c, mon_e.lv, mon_e.pr, mon_e.rl, mon_e.mv, mon_e.ap);
        end
      end
    end
  end
  task automatic hold(logic [3:0] m, int len);
    bus.btn_n = bus.btn_n & ~m;
    repeat (len) @(negedge clk);
    bus.btn_n = bus.btn_n | m;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.btn_n = '1;
    idle(3);
    check("reset_outputs", 32'({bus.level, bus.press, bus.rel, bus.move, bus.any_press}), 0);
    reset = 1'b1;
    idle(3);
    // clean press and release on p1l
    @(negedge clk);
    k = cyc + 1;
    expect_ev(k + 5, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    expect_ev(k + 11, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    hold(4'b0001 << BTN_P1L, 6);
    idle(15);
    // bounce on p1r: low 3, high 1, low 3 never qualifies
    @(negedge clk);
    hold(4'b0001 << BTN_P1R, 3);
    idle(1);
    hold(4'b0001 << BTN_P1R, 3);
    idle(12);
    check("bounce_level", 32'(bus.level), 0);
    // auto-repeat on p2l; release lands on a would-be repeat edge
    @(negedge clk);
    k = cyc + 1;
    expect_ev(k + 5, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
`ifdef AUTOREPEAT_EN
    for (int t = 15; t <= 24; t += 3) expect_ev(k + t, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
`endif
    expect_ev(k + 27, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    hold(4'b0001 << BTN_P2L, 22);
    idle(15);
    // simultaneous presses on p1l and p1r
    @(negedge clk);
    k = cyc + 1;
    expect_ev(k + 5, 4'b0011, 4'b0011, 4'b0000, 4'b0011);
    expect_ev(k + 11, 4'b0000, 4'b0000, 4'b0011, 4'b0000);
    hold(4'b0011, 6);
    idle(15);
    // reset while p2r is held
    @(negedge clk);
    k = cyc + 1;
    expect_ev(k + 5, 4'b1000, 4'b1000, 4'b0000, 4'b1000);
    bus.btn_n[BTN_P2R] = 1'b0;
    idle(8);
    check("held_level", 32'(bus.level), 32'h8);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'({bus.level, bus.press, bus.rel, bus.move, bus.any_press}), 0);
    idle(2);
    reset = 1'b1;
    r = cyc + 1;
    expect_ev(r + 5, 4'b1000, 4'b1000, 4'b0000, 4'b1000);
    expect_ev(r + 11, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    idle(6);
    check("requalified_level", 32'(bus.level), 32'h8);
    bus.btn_n[BTN_P2R] = 1'b1;
    idle(15);
    // long hold on p1l: single move without auto-repeat, repeat train with it
    @(negedge clk);
    k = cyc + 1;
    expect_ev(k + 5, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
`ifdef AUTOREPEAT_EN
    for (int t = 15; t < 45; t += 3) expect_ev(k + t, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`endif
    expect_ev(k + 45, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    hold(4'b0001 << BTN_P1L, 40);
    idle(15);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
